// File: rtl/tppe_pkg.sv
// Shared types for the TPPE fibre_a memory path: spike words, fibre
// addresses and the responder's two-state controller encoding.
package tppe_pkg;

    localparam int FA_TIMESTEPS  = 4;
    localparam int FA_ADDR_WIDTH = 8;

    typedef logic [FA_TIMESTEPS-1:0]  spike_word_t;
    typedef logic [FA_ADDR_WIDTH-1:0] fibre_addr_t;

    typedef enum logic {
        INIT_CLEAR = 1'b0,
        SERVE      = 1'b1
    } fa_state_t;

endpackage

// File: rtl/fibre_a_mem_server_if.sv
// Bundle of the fibre_a read port, the side write port and the status
// outputs. The accelerator/loader side is the master, the memory the slave.
interface fibre_a_mem_server_if #(
    parameter int TIMESTEPS  = 4,
    parameter int ADDR_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
);

    logic [ADDR_WIDTH-1:0] fibre_a_addr;
    logic                  fibre_a_read_en;
    logic [TIMESTEPS-1:0]  fibre_a_data;
    logic                  fibre_a_valid;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [TIMESTEPS-1:0]  wr_data;
    logic                  mem_ready;
    logic                  addr_err;
    logic [CNT_WIDTH-1:0]  read_count;

    modport master (
        output fibre_a_addr, fibre_a_read_en, wr_en, wr_addr, wr_data,
        input  fibre_a_data, fibre_a_valid, mem_ready, addr_err, read_count
    );

    modport slave (
        input  fibre_a_addr, fibre_a_read_en, wr_en, wr_addr, wr_data,
        output fibre_a_data, fibre_a_valid, mem_ready, addr_err, read_count
    );

endinterface

// File: rtl/fa_read_pipe.sv
// Fixed-latency delay line for the read response {valid, data}.
// Only the valid bits are reset, so a reset drops every in-flight response.
// The final data register is also cleared so the output port reads 0 out of
// reset; it loads only on a valid response and otherwise holds its value.
module fa_read_pipe #(
    parameter int DATA_W       = 4,
    parameter int READ_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              vld_in,
    input  logic [DATA_W-1:0] data_in,
    output logic              vld_out,
    output logic [DATA_W-1:0] data_out
);

    logic              last_vld;
    logic [DATA_W-1:0] last_data;

    if (READ_LATENCY == 1) begin : g_direct
        assign last_vld  = vld_in;
        assign last_data = data_in;
    end else begin : g_delay
        logic [READ_LATENCY-2:0] vld_p;
        logic [DATA_W-1:0]       data_p [READ_LATENCY-1];

        // Valid shift chain, flushed by reset.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                vld_p <= '0;
            end else begin
                vld_p[0] <= vld_in;
                for (int i = 1; i < READ_LATENCY - 1; i++) begin
                    vld_p[i] <= vld_p[i-1];
                end
            end
        end

        // Data shift chain; contents are qualified by vld_p, so no reset.
        always_ff @(posedge clk) begin
            data_p[0] <= data_in;
            for (int i = 1; i < READ_LATENCY - 1; i++) begin
                data_p[i] <= data_p[i-1];
            end
        end

        assign last_vld  = vld_p[READ_LATENCY-2];
        assign last_data = data_p[READ_LATENCY-2];
    end

    // Output stage: single-cycle valid pulse, data held between responses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_out  <= 1'b0;
            data_out <= '0;
        end else begin
            vld_out <= last_vld;
            if (last_vld) begin
                data_out <= last_data;
            end
        end
    end

endmodule

// File: rtl/fibre_a_mem_server.sv
// fibre_a memory responder: one spike word per address, answered after a
// fixed latency. After reset a clear sweep zeroes the array one word per
// cycle; reads are answered throughout (as 0 during the sweep), writes only
// once the sweep has finished.
module fibre_a_mem_server
    import tppe_pkg::*;
#(
    parameter int TIMESTEPS    = 4,
    parameter int ADDR_WIDTH   = 8,
    parameter int DEPTH        = 256,
    parameter int READ_LATENCY = 1,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    fibre_a_mem_server_if.slave  bus
);

    // One extra bit so DEPTH = 2^ADDR_WIDTH is representable.
    localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_PTR  = ADDR_WIDTH'(DEPTH - 1);

    fa_state_t             state;
    logic [ADDR_WIDTH-1:0] clr_ptr;
    logic                  mem_ready_q;
    logic                  addr_err_q;
    logic [CNT_WIDTH-1:0]  read_count_q;

    logic [TIMESTEPS-1:0]  mem [DEPTH];

    logic                  serving;
    logic                  rd_in_range;
    logic                  wr_in_range;
    logic                  wr_accept;
    logic                  err_event;
    logic [TIMESTEPS-1:0]  rd_word;

    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
        return {1'b0, a} < DEPTH_EXT;
    endfunction

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + CNT_WIDTH'(1);
    endfunction

    assign serving     = (state == SERVE);
    assign rd_in_range = in_range(bus.fibre_a_addr);
    assign wr_in_range = in_range(bus.wr_addr);
    assign wr_accept   = serving && bus.wr_en && wr_in_range;
    // Writes during the sweep are dropped without flagging an error.
    assign err_event   = (bus.fibre_a_read_en && !rd_in_range)
                       || (serving && bus.wr_en && !wr_in_range);

    // Read word sampled in the accept cycle; a same-cycle write to the same
    // address wins over the stored word.
    always_comb begin
        rd_word = '0;
        if (serving && rd_in_range) begin
            if (wr_accept && (bus.wr_addr == bus.fibre_a_addr)) begin
                rd_word = bus.wr_data;
            end else begin
                rd_word = mem[bus.fibre_a_addr];
            end
        end
    end

    // Single array write port: the sweep owns it until service begins.
    always_ff @(posedge clk) begin
        if (!serving) begin
            mem[clr_ptr] <= '0;
        end else if (wr_accept) begin
            mem[bus.wr_addr] <= bus.wr_data;
        end
    end

    // Controller: clear sweep over every address, then steady service.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= INIT_CLEAR;
            clr_ptr     <= '0;
            mem_ready_q <= 1'b0;
        end else begin
            case (state)
                INIT_CLEAR: begin
                    clr_ptr <= clr_ptr + ADDR_WIDTH'(1);
                    if (clr_ptr == LAST_PTR) begin
                        state       <= SERVE;
                        mem_ready_q <= 1'b1;
                    end
                end
                SERVE: begin
                    mem_ready_q <= 1'b1;
                end
            endcase
        end
    end

    // Sticky address error and saturating count of accepted reads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_err_q   <= 1'b0;
            read_count_q <= '0;
        end else begin
            if (err_event) begin
                addr_err_q <= 1'b1;
            end
            if (bus.fibre_a_read_en) begin
                read_count_q <= sat_inc(read_count_q);
            end
        end
    end

    fa_read_pipe #(
        .DATA_W       (TIMESTEPS),
        .READ_LATENCY (READ_LATENCY)
    ) u_read_pipe (
        .clk      (clk),
        .rst      (rst),
        .vld_in   (bus.fibre_a_read_en),
        .data_in  (rd_word),
        .vld_out  (bus.fibre_a_valid),
        .data_out (bus.fibre_a_data)
    );

    assign bus.mem_ready  = mem_ready_q;
    assign bus.addr_err   = addr_err_q;
    assign bus.read_count = read_count_q;

endmodule

// File: tb/tb_fibre_a_mem_server.sv
// Bench for fibre_a_mem_server. Three instances share one stimulus stream:
//   0: DEPTH 256, latency 1, 16-bit counter
//   1: DEPTH 256, latency 3, 4-bit counter
//   2: DEPTH 200, latency 2, 16-bit counter
// A reference model (word array, edges since reset, scheduled responses)
// predicts every output.
module tb_fibre_a_mem_server;
    import tppe_pkg::*;

    localparam int ND = 3;

    logic        clk = 1'b0;
    logic        rst;
    fibre_addr_t addr;
    fibre_addr_t waddr;
    logic        ren;
    logic        wen;
    spike_word_t wdata;

    always #5 clk = ~clk;

    fibre_a_mem_server_if #(.TIMESTEPS(4), .ADDR_WIDTH(8), .CNT_WIDTH(16)) bus_a ();
    fibre_a_mem_server_if #(.TIMESTEPS(4), .ADDR_WIDTH(8), .CNT_WIDTH(4))  bus_b ();
    fibre_a_mem_server_if #(.TIMESTEPS(4), .ADDR_WIDTH(8), .CNT_WIDTH(16)) bus_c ();

    assign bus_a.fibre_a_addr = addr;  assign bus_a.fibre_a_read_en = ren;
    assign bus_a.wr_en = wen;          assign bus_a.wr_addr = waddr;  assign bus_a.wr_data = wdata;
    assign bus_b.fibre_a_addr = addr;  assign bus_b.fibre_a_read_en = ren;
    assign bus_b.wr_en = wen;          assign bus_b.wr_addr = waddr;  assign bus_b.wr_data = wdata;
    assign bus_c.fibre_a_addr = addr;  assign bus_c.fibre_a_read_en = ren;
    assign bus_c.wr_en = wen;          assign bus_c.wr_addr = waddr;  assign bus_c.wr_data = wdata;

    fibre_a_mem_server #(.TIMESTEPS(4), .ADDR_WIDTH(8), .DEPTH(256), .READ_LATENCY(1), .CNT_WIDTH(16))
        dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    fibre_a_mem_server #(.TIMESTEPS(4), .ADDR_WIDTH(8), .DEPTH(256), .READ_LATENCY(3), .CNT_WIDTH(4))
        dut_b (.clk(clk), .rst(rst), .bus(bus_b));
    fibre_a_mem_server #(.TIMESTEPS(4), .ADDR_WIDTH(8), .DEPTH(200), .READ_LATENCY(2), .CNT_WIDTH(16))
        dut_c (.clk(clk), .rst(rst), .bus(bus_c));

    logic        o_vld  [ND];
    logic [3:0]  o_data [ND];
    logic        o_rdy  [ND];
    logic        o_err  [ND];
    logic [15:0] o_cnt  [ND];

    assign o_vld[0] = bus_a.fibre_a_valid; assign o_data[0] = bus_a.fibre_a_data;
    assign o_rdy[0] = bus_a.mem_ready;     assign o_err[0]  = bus_a.addr_err;
    assign o_cnt[0] = bus_a.read_count;
    assign o_vld[1] = bus_b.fibre_a_valid; assign o_data[1] = bus_b.fibre_a_data;
    assign o_rdy[1] = bus_b.mem_ready;     assign o_err[1]  = bus_b.addr_err;
    assign o_cnt[1] = {12'd0, bus_b.read_count};
    assign o_vld[2] = bus_c.fibre_a_valid; assign o_data[2] = bus_c.fibre_a_data;
    assign o_rdy[2] = bus_c.mem_ready;     assign o_err[2]  = bus_c.addr_err;
    assign o_cnt[2] = bus_c.read_count;

    // Reference model state
    int         cyc;
    logic [3:0] mmem   [ND][256];
    int         edges  [ND];
    logic       m_err  [ND];
    int         m_cnt  [ND];
    logic       m_vld  [ND];
    logic [3:0] m_last [ND];
    logic       ring_v [ND][8];
    logic [3:0] ring_d [ND][8];

    int checks = 0;
    int errors = 0;

    function automatic int dep(input int d);
        return (d == 2) ? 200 : 256;
    endfunction

    function automatic int lat(input int d);
        return (d == 0) ? 1 : ((d == 1) ? 3 : 2);
    endfunction

    function automatic int cmax(input int d);
        return (d == 1) ? 15 : 65535;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < ND; d++) begin
            for (int a = 0; a < 256; a++) mmem[d][a] = 4'h0;
            edges[d]  = 0;
            m_err[d]  = 1'b0;
            m_cnt[d]  = 0;
            m_vld[d]  = 1'b0;
            m_last[d] = 4'h0;
            for (int s = 0; s < 8; s++) begin
                ring_v[d][s] = 1'b0;
                ring_d[d][s] = 4'h0;
            end
        end
    endtask

    task automatic idle();
        ren = 1'b0;
        wen = 1'b0;
    endtask

    // Advance one clock: apply the current request to the model, take the
    // edge, then expose the model's expected outputs for this new cycle.
    task automatic tick();
        logic       serving;
        logic [3:0] rd;
        if (!rst) begin
            for (int d = 0; d < ND; d++) begin
                serving = (edges[d] >= dep(d));
                if (serving && wen) begin
                    if (int'(waddr) < dep(d)) mmem[d][waddr] = wdata;
                    else m_err[d] = 1'b1;
                end
                if (ren) begin
                    rd = (serving && int'(addr) < dep(d)) ? mmem[d][addr] : 4'h0;
                    ring_v[d][(cyc + lat(d)) % 8] = 1'b1;
                    ring_d[d][(cyc + lat(d)) % 8] = rd;
                    if (m_cnt[d] < cmax(d)) m_cnt[d]++;
                    if (int'(addr) >= dep(d)) m_err[d] = 1'b1;
                end
                if (edges[d] < 100000) edges[d]++;
            end
        end
        @(posedge clk);
        cyc++;
        for (int d = 0; d < ND; d++) begin
            m_vld[d] = ring_v[d][cyc % 8];
            if (m_vld[d]) m_last[d] = ring_d[d][cyc % 8];
            ring_v[d][cyc % 8] = 1'b0;
        end
        #1;
    endtask

    task automatic test_reset();
        int         n   [ND];
        logic [3:0] got [ND];
        int         at  [ND];
        idle();
        rst = 1'b1;
        model_reset();
        repeat (3) tick();
        for (int d = 0; d < ND; d++) begin
            checks++;
            if (o_vld[d] !== 1'b0) begin errors++; $display("FAIL reset_valid dut%0d: got %b want 0", d, o_vld[d]); end
            checks++;
            if (o_data[d] !== 4'h0) begin errors++; $display("FAIL reset_data dut%0d: got %h want 0", d, o_data[d]); end
            checks++;
            if (o_rdy[d] !== 1'b0) begin errors++; $display("FAIL reset_ready dut%0d: got %b want 0", d, o_rdy[d]); end
            checks++;
            if (o_err[d] !== 1'b0) begin errors++; $display("FAIL reset_err dut%0d: got %b want 0", d, o_err[d]); end
            checks++;
            if (o_cnt[d] !== 16'd0) begin errors++; $display("FAIL reset_count dut%0d: got %0d want 0", d, o_cnt[d]); end
        end
        rst = 1'b0;
        // Clear sweep with random traffic; writes stop before any instance is ready.
        for (int k = 1; k <= 262; k++) begin
            ren   = (k < 250) ? 1'($urandom_range(0, 1)) : 1'b0;
            addr  = 8'($urandom);
            wen   = (k < 196) ? 1'($urandom_range(0, 1)) : 1'b0;
            waddr = 8'($urandom);
            wdata = 4'($urandom);
            tick();
            for (int d = 0; d < ND; d++) begin
                checks++;
                if (o_rdy[d] !== (k >= dep(d))) begin
                    errors++;
                    $display("FAIL sweep_ready dut%0d cycle %0d: got %b want %b", d, k, o_rdy[d], (k >= dep(d)));
                end
                checks++;
                if (o_vld[d] !== m_vld[d] || o_data[d] !== m_last[d]) begin
                    errors++;
                    $display("FAIL sweep_read dut%0d cycle %0d: got %b/%h want %b/%h", d, k, o_vld[d], o_data[d], m_vld[d], m_last[d]);
                end
            end
        end
        idle();
        for (int d = 0; d < ND; d++) n[d] = 0;
        for (int t = 0; t < 4; t++) begin
            ren  = (t == 0);
            addr = 8'h10;
            tick();
            for (int d = 0; d < ND; d++) if (o_vld[d] && n[d] < 1) begin got[d] = o_data[d]; at[d] = t; n[d]++; end
        end
        for (int d = 0; d < ND; d++) begin
            checks++;
            if (n[d] != 1 || got[d] !== 4'h0 || at[d] != lat(d) - 1) begin
                errors++;
                $display("FAIL first_read dut%0d: got pulses=%0d data=%h at=%0d want 1/0/%0d", d, n[d], got[d], at[d], lat(d) - 1);
            end
        end
    endtask

    task automatic test_write_read();
        int         n   [ND];
        logic [3:0] got [ND][4];
        int         at  [ND][4];
        logic [3:0] want;
        idle();
        wen = 1'b1; waddr = 8'h05; wdata = 4'hA; tick();
        waddr = 8'h06; wdata = 4'h3; tick();
        wen = 1'b0;
        for (int d = 0; d < ND; d++) n[d] = 0;
        for (int t = 0; t < 7; t++) begin
            ren  = (t < 3);
            addr = (t == 1) ? 8'h06 : 8'h05;
            tick();
            for (int d = 0; d < ND; d++) if (o_vld[d] && n[d] < 4) begin got[d][n[d]] = o_data[d]; at[d][n[d]] = t; n[d]++; end
        end
        idle();
        for (int d = 0; d < ND; d++) begin
            checks++;
            if (n[d] != 3) begin errors++; $display("FAIL b2b_pulses dut%0d: got %0d want 3", d, n[d]); end
            for (int i = 0; i < 3; i++) begin
                if (i < n[d]) begin
                    want = (i == 1) ? 4'h3 : 4'hA;
                    checks++;
                    if (got[d][i] !== want || at[d][i] != lat(d) - 1 + i) begin
                        errors++;
                        $display("FAIL b2b_data dut%0d #%0d: got %h at %0d want %h at %0d", d, i, got[d][i], at[d][i], want, lat(d) - 1 + i);
                    end
                end
            end
        end
    endtask

    task automatic test_bypass();
        int         n   [ND];
        logic [3:0] got [ND];
        int         at  [ND];
        idle();
        wen = 1'b1; waddr = 8'h20; wdata = 4'h1; tick();
        for (int d = 0; d < ND; d++) n[d] = 0;
        for (int t = 0; t < 4; t++) begin
            wen = (t == 0); waddr = 8'h20; wdata = 4'h9;
            ren = (t == 0); addr  = 8'h20;
            tick();
            for (int d = 0; d < ND; d++) if (o_vld[d] && n[d] < 1) begin got[d] = o_data[d]; at[d] = t; n[d]++; end
        end
        idle();
        for (int d = 0; d < ND; d++) begin
            checks++;
            if (n[d] != 1 || got[d] !== 4'h9 || at[d] != lat(d) - 1) begin
                errors++;
                $display("FAIL bypass dut%0d: got pulses=%0d data=%h at=%0d want 1/9/%0d", d, n[d], got[d], at[d], lat(d) - 1);
            end
        end
    endtask

    task automatic test_out_of_range();
        int         n   [ND];
        logic [3:0] got [ND];
        logic [3:0] want;
        idle();
        for (int d = 0; d < ND; d++) n[d] = 0;
        for (int t = 0; t < 4; t++) begin
            ren = (t == 0); addr = 8'hF0;
            tick();
            if (t == 0) begin
                for (int d = 0; d < ND; d++) begin
                    checks++;
                    if (o_err[d] !== (d == 2)) begin errors++; $display("FAIL oor_err_rise dut%0d: got %b want %b", d, o_err[d], (d == 2)); end
                end
            end
            for (int d = 0; d < ND; d++) if (o_vld[d] && n[d] < 1) begin got[d] = o_data[d]; n[d]++; end
        end
        for (int d = 0; d < ND; d++) begin
            checks++;
            if (n[d] != 1 || got[d] !== 4'h0) begin errors++; $display("FAIL oor_read dut%0d: got pulses=%0d data=%h want 1/0", d, n[d], got[d]); end
        end
        wen = 1'b1; waddr = 8'hF1; wdata = 4'h7; ren = 1'b0; tick();
        wen = 1'b0;
        for (int d = 0; d < ND; d++) n[d] = 0;
        for (int t = 0; t < 4; t++) begin
            ren = (t == 0); addr = 8'hF1;
            tick();
            for (int d = 0; d < ND; d++) if (o_vld[d] && n[d] < 1) begin got[d] = o_data[d]; n[d]++; end
        end
        idle();
        for (int d = 0; d < ND; d++) begin
            want = (d == 2) ? 4'h0 : 4'h7;
            checks++;
            if (n[d] != 1 || got[d] !== want) begin errors++; $display("FAIL oor_write dut%0d: got pulses=%0d data=%h want 1/%h", d, n[d], got[d], want); end
            checks++;
            if (o_err[d] !== (d == 2)) begin errors++; $display("FAIL oor_err_sticky dut%0d: got %b want %b", d, o_err[d], (d == 2)); end
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            ren   = 1'($urandom_range(0, 1));
            wen   = 1'($urandom_range(0, 1));
            addr  = 8'($urandom_range(8'hC4, 8'hCB));
            waddr = ($urandom_range(0, 3) == 0) ? addr : 8'($urandom_range(8'hC4, 8'hCB));
            wdata = 4'($urandom);
            tick();
            for (int d = 0; d < ND; d++) begin
                checks++;
                if (o_vld[d] !== m_vld[d] || o_data[d] !== m_last[d]) begin
                    errors++;
                    $display("FAIL rand_read dut%0d step %0d: got %b/%h want %b/%h", d, k, o_vld[d], o_data[d], m_vld[d], m_last[d]);
                end
                checks++;
                if (o_err[d] !== m_err[d] || int'(o_cnt[d]) != m_cnt[d] || o_rdy[d] !== 1'b1) begin
                    errors++;
                    $display("FAIL rand_status dut%0d step %0d: got err=%b cnt=%0d rdy=%b want %b/%0d/1", d, k, o_err[d], o_cnt[d], o_rdy[d], m_err[d], m_cnt[d]);
                end
            end
        end
        idle();
        repeat (4) tick();
    endtask

    task automatic test_saturation();
        int want;
        idle();
        rst = 1'b1;
        model_reset();
        repeat (2) tick();
        rst = 1'b0;
        for (int k = 0; k < 20; k++) begin
            ren = 1'b1; addr = 8'($urandom);
            tick();
        end
        idle();
        repeat (4) tick();
        for (int d = 0; d < ND; d++) begin
            want = (d == 1) ? 15 : 20;
            checks++;
            if (int'(o_cnt[d]) != want) begin errors++; $display("FAIL count_sat dut%0d: got %0d want %0d", d, o_cnt[d], want); end
        end
        repeat (240) tick();
        for (int d = 0; d < ND; d++) begin
            checks++;
            if (o_rdy[d] !== 1'b1) begin errors++; $display("FAIL sat_ready dut%0d: got %b want 1", d, o_rdy[d]); end
        end
    endtask

    task automatic test_midflight_reset();
        idle();
        ren = 1'b1; addr = 8'h05; tick();
        addr = 8'h06; tick();
        idle();
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        for (int d = 0; d < ND; d++) begin
            checks++;
            if (o_vld[d] !== 1'b0 || o_cnt[d] !== 16'd0 || o_rdy[d] !== 1'b0) begin
                errors++;
                $display("FAIL midrst_async dut%0d: got vld=%b cnt=%0d rdy=%b want 0/0/0", d, o_vld[d], o_cnt[d], o_rdy[d]);
            end
        end
        tick();
        rst = 1'b0;
        for (int k = 1; k <= 262; k++) begin
            tick();
            for (int d = 0; d < ND; d++) begin
                checks++;
                if (o_vld[d] !== 1'b0 || o_cnt[d] !== 16'd0) begin
                    errors++;
                    $display("FAIL midrst_flush dut%0d cycle %0d: got vld=%b cnt=%0d want 0/0", d, k, o_vld[d], o_cnt[d]);
                end
                checks++;
                if (o_rdy[d] !== (k >= dep(d))) begin
                    errors++;
                    $display("FAIL midrst_ready dut%0d cycle %0d: got %b want %b", d, k, o_rdy[d], (k >= dep(d)));
                end
            end
        end
    endtask

    initial begin
        cyc   = 0;
        rst   = 1'b1;
        addr  = '0;
        waddr = '0;
        wdata = '0;
        idle();
        model_reset();
        test_reset();
        test_write_read();
        test_bypass();
        test_out_of_range();
        test_random();
        test_saturation();
        test_midflight_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
